mtm_alu_req_arbiter: RTL
========================

// Module: mtm_alu_req_arbiter
// PURPOSE
//  Shares one serial mtm_Alu between NUM_REQ parallel requesters.
//  - Arbitrates requests round-robin.
//  - Serialises the winner's operands and opcode onto sin, framed and with CRC4 appended.
//  - Deserialises the ALU reply from sout and returns it to the winning requester.
//  - Exactly one transaction is in flight at a time.
//  Sits between the testbench/SoC command sources and the mtm_Alu DUT pins.
// PARAMETERS
//  NUM_REQ      2     number of requesters (2..8)
//  TIMEOUT_CYC  200   cycles allowed from last sin stop bit to reply start bit on sout
// PORTS
//  One clock; reset is synchronous and active-high.
//  clk         in   1          system clock; sin driven and sout sampled on rising edge
//  rst         in   1          synchronous active-high reset
//  req_valid   in   NUM_REQ    requester i has an operation pending
//  req_ready   out  NUM_REQ    1-cycle pulse: request i accepted; operands captured this cycle
//  req_a       in   32*NUM_REQ operand A, slice i
//  req_b       in   32*NUM_REQ operand B, slice i
//  req_op      in   3*NUM_REQ  opcode, slice i
//  rsp_valid   out  NUM_REQ    1-cycle pulse to the requester that owned the transaction
//  rsp_result  out  32         ALU result; valid with rsp_valid
//  rsp_ctl     out  8          raw reply CTL byte; flags or error bits
//  rsp_status  out  2          00 OK data frame, 01 ALU error frame, 10 timeout
//  sin         out  1          serial line to ALU; idle 1
//  sout        in   1          serial line from ALU; idle 1
// BEHAVIOUR
//  Byte frame: 11 bits, one per clk, in this order:
//   - start 0
//   - type bit (0 data, 1 ctl)
//   - d[7:0], MSB first
//   - stop 1
//  Request frame: 9 bytes back-to-back, 99 cycles in total.
//   - Bytes 1-8 are type 0: A[31:24] .. A[7:0], then B[31:24] .. B[7:0].
//   - Byte 9 is type 1: CTL = {1'b0, op[2:0], crc[3:0]}.
//   - crc = CRC4, poly x^4+x+1, init 0, computed over the 68 bits {A, B, 1'b1, op}, MSB first.
//  Reply frame is either:
//   - data: 5 bytes = 4 type-0 bytes (result, MSB first) + 1 type-1 CTL byte, 55 bits;
//   - error: 1 type-1 byte, 11 bits.
//   The frame kind is decided by the type bit of the first reply byte. Reply CRC is not checked.
//  Reset values:
//   - sin = 1; req_ready = 0; rsp_valid = 0; rsp_result = 0; rsp_ctl = 0; rsp_status = 0
//   - state = IDLE; round-robin pointer = 0
//  FSM:
//   - IDLE: if any req_valid, go to ARB next cycle.
//   - ARB: grant the first valid index at or after the pointer, wrapping modulo NUM_REQ.
//     Pulse req_ready[g], latch A/B/op, set pointer = g+1 (wraps), start CRC, go to SEND.
//   - SEND: drive the 99 frame bits, one per cycle. First start bit on the cycle after ARB.
//     After the final stop bit: sin = 1, go to WAIT.
//   - WAIT: count cycles. On sout == 0, go to RECV; that cycle is bit 0.
//     If the count reaches TIMEOUT_CYC, go to DONE with status 10.
//   - RECV: shift sout for 11 or 55 bits in total, per the type bit, then go to DONE.
//     Error frame -> status 01 and result 0.
//   - DONE: for one cycle, pulse rsp_valid[g] and present rsp_* ; then go to IDLE.
//  Latency:
//   - req_valid seen in IDLE -> req_ready pulse 2 cycles later.
//   - Data reply: rsp_valid 1 cycle after the last reply bit.
//  Requester contract: req_valid is held until req_ready. Dropping req_valid before the grant is legal.
//  A requester may re-assert req_valid in the same cycle it receives its rsp_valid pulse;
//  that request is considered in the next IDLE -> ARB.
//  rsp_result/rsp_ctl/rsp_status hold their last value between pulses.
//  Reset asserted mid-SEND/WAIT/RECV: abort the transaction.
//   - sin = 1 on the next edge; no rsp_valid for the aborted transaction.
//   - Pointer returns to 0.
//  sout low during SEND is ignored; no full-duplex operation.
// TESTING
//  1. After reset, only req 0: ADD, A=1, B=2.
//     -> sin carries 99 bits with CTL = 0x0_op_crc per reference CRC.
//     -> ALU model replies 3 -> rsp_valid[0] for 1 cycle, result 0x3, status 00.
//  2. req 0 and req 1 asserted together, three rounds.
//     -> grant order 0, 1, 0, 1, 0, 1; never two outstanding.
//  3. ALU model returns error frame 0b0_1_11001001_1.
//     -> rsp_status 01, rsp_ctl 0xC9, rsp_result 0.
//  4. Model never replies.
//     -> rsp_valid with status 10 exactly TIMEOUT_CYC cycles after the last stop bit.
//     -> Next request proceeds normally.
//  5. rst asserted during byte 4 of SEND.
//     -> sin = 1 next cycle, no rsp_valid.
//     -> Fresh request after reset is granted to index 0.
//  6. Random A/B/op, 1000 transactions, 2 requesters.
//     -> every rsp matches the scoreboard; per-requester response count equals grant count.

Source files
------------

// File: rtl/mtm_alu_req_arbiter.sv
// Round-robin arbiter that shares one serial mtm_Alu between NUM_REQ requesters:
// frames the winner's operands onto sin and returns the deserialised sout reply.
module mtm_alu_req_arbiter #(
    parameter int unsigned NUM_REQ     = 2,
    parameter int unsigned TIMEOUT_CYC = 200
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [NUM_REQ-1:0]      req_valid,
    output logic [NUM_REQ-1:0]      req_ready,
    input  logic [32*NUM_REQ-1:0]   req_a,
    input  logic [32*NUM_REQ-1:0]   req_b,
    input  logic [3*NUM_REQ-1:0]    req_op,
    output logic [NUM_REQ-1:0]      rsp_valid,
    output logic [31:0]             rsp_result,
    output logic [7:0]              rsp_ctl,
    output logic [1:0]              rsp_status,
    output logic                    sin,
    input  logic                    sout
);

    localparam int unsigned PTR_W      = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int unsigned WAIT_W     = $clog2(TIMEOUT_CYC + 1);
    localparam int unsigned FRAME_BITS = 99;

    typedef enum logic [2:0] {IDLE, ARB, SEND, WAIT, RECV, DONE} state_t;

    state_t                  state;
    logic [PTR_W-1:0]        ptr;
    logic [PTR_W-1:0]        owner;
    logic [FRAME_BITS-2:0]   frame_sr;
    logic [6:0]              bit_cnt;
    logic [WAIT_W-1:0]       wait_cnt;
    logic [51:0]             rx_sr;
    logic [5:0]              rx_cnt;
    logic                    rx_type;

    logic                    grant_found;
    logic [PTR_W-1:0]        grant_idx;
    logic [PTR_W-1:0]        cand;
    logic [31:0]             a_arr  [NUM_REQ];
    logic [31:0]             b_arr  [NUM_REQ];
    logic [2:0]              op_arr [NUM_REQ];
    logic [31:0]             sel_a;
    logic [31:0]             sel_b;
    logic [2:0]              sel_op;
    logic [3:0]              crc;
    logic [FRAME_BITS-1:0]   frame;
    logic [NUM_REQ-1:0]      owner_mask;

    for (genvar i = 0; i < NUM_REQ; i++) begin : g_unpack
        assign a_arr[i]  = req_a[32*i +: 32];
        assign b_arr[i]  = req_b[32*i +: 32];
        assign op_arr[i] = req_op[3*i +: 3];
    end

    // CRC4, x^4+x+1, init 0, MSB first
    function automatic logic [3:0] crc4(input logic [67:0] bits);
        logic [3:0] c;
        logic       fb;
        c = '0;
        for (int i = 67; i >= 0; i--) begin
            fb = c[3] ^ bits[i];
            c  = {c[2:0], 1'b0} ^ {2'b00, fb, fb};
        end
        return c;
    endfunction

    function automatic logic [10:0] byte_frame(input logic typ, input logic [7:0] d);
        return {1'b0, typ, d, 1'b1};
    endfunction

    // First valid requester at or after the pointer, wrapping
    always_comb begin
        grant_found = 1'b0;
        grant_idx   = '0;
        cand        = '0;
        for (int unsigned k = 0; k < NUM_REQ; k++) begin
            cand = PTR_W'((32'(ptr) + k) % NUM_REQ);
            if (!grant_found && req_valid[cand]) begin
                grant_found = 1'b1;
                grant_idx   = cand;
            end
        end
    end

    assign sel_a      = a_arr[grant_idx];
    assign sel_b      = b_arr[grant_idx];
    assign sel_op     = op_arr[grant_idx];
    assign crc        = crc4({sel_a, sel_b, 1'b1, sel_op});
    assign owner_mask = NUM_REQ'(1) << owner;

    assign frame = {byte_frame(1'b0, sel_a[31:24]), byte_frame(1'b0, sel_a[23:16]),
                    byte_frame(1'b0, sel_a[15:8]),  byte_frame(1'b0, sel_a[7:0]),
                    byte_frame(1'b0, sel_b[31:24]), byte_frame(1'b0, sel_b[23:16]),
                    byte_frame(1'b0, sel_b[15:8]),  byte_frame(1'b0, sel_b[7:0]),
                    byte_frame(1'b1, {1'b0, sel_op, crc})};

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            ptr        <= '0;
            owner      <= '0;
            sin        <= 1'b1;
            req_ready  <= '0;
            rsp_valid  <= '0;
            rsp_result <= '0;
            rsp_ctl    <= '0;
            rsp_status <= '0;
            frame_sr   <= '0;
            bit_cnt    <= '0;
            wait_cnt   <= '0;
            rx_sr      <= '0;
            rx_cnt     <= '0;
            rx_type    <= 1'b0;
        end else begin
            req_ready <= '0;
            rsp_valid <= '0;
            case (state)
                IDLE: begin
                    if (|req_valid) state <= ARB;
                end
                ARB: begin
                    // requester may have withdrawn since IDLE
                    if (grant_found) begin
                        req_ready <= NUM_REQ'(1) << grant_idx;
                        owner     <= grant_idx;
                        ptr       <= (grant_idx == PTR_W'(NUM_REQ - 1)) ? '0 : grant_idx + PTR_W'(1);
                        sin       <= frame[FRAME_BITS-1];
                        frame_sr  <= frame[FRAME_BITS-2:0];
                        bit_cnt   <= 7'd1;
                        state     <= SEND;
                    end else begin
                        state <= IDLE;
                    end
                end
                SEND: begin
                    if (bit_cnt == 7'(FRAME_BITS)) begin
                        sin      <= 1'b1;
                        wait_cnt <= WAIT_W'(1);
                        state    <= WAIT;
                    end else begin
                        sin      <= frame_sr[FRAME_BITS-2];
                        frame_sr <= {frame_sr[FRAME_BITS-3:0], 1'b0};
                        bit_cnt  <= bit_cnt + 7'd1;
                    end
                end
                WAIT: begin
                    if (!sout) begin
                        rx_sr  <= '0;
                        rx_cnt <= 6'd1;
                        state  <= RECV;
                    end else if (32'(wait_cnt) + 32'd1 >= TIMEOUT_CYC) begin
                        rsp_valid  <= owner_mask;
                        rsp_result <= '0;
                        rsp_ctl    <= '0;
                        rsp_status <= 2'b10;
                        state      <= DONE;
                    end else begin
                        wait_cnt <= wait_cnt + WAIT_W'(1);
                    end
                end
                RECV: begin
                    rx_sr  <= {rx_sr[50:0], sout};
                    rx_cnt <= rx_cnt + 6'd1;
                    if (rx_cnt == 6'd1) rx_type <= sout;
                    // current sout is the stop bit of the last byte
                    if (rx_type && rx_cnt == 6'd10) begin
                        rsp_valid  <= owner_mask;
                        rsp_result <= '0;
                        rsp_ctl    <= rx_sr[7:0];
                        rsp_status <= 2'b01;
                        state      <= DONE;
                    end else if (rx_cnt == 6'd54) begin
                        rsp_valid  <= owner_mask;
                        rsp_result <= {rx_sr[51:44], rx_sr[40:33], rx_sr[29:22], rx_sr[18:11]};
                        rsp_ctl    <= rx_sr[7:0];
                        rsp_status <= 2'b00;
                        state      <= DONE;
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
